dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port data RAM between two requesters: the MCU control unit (LOAD/ADD/SUB operand fetch, STORE) and a host/debug port.
- Issues at most one RAM command per cycle.
- Returns read data one cycle after the command.
- Asserts a stall to the MCU while its request is pending.
- Sits between mcu/regs and the data RAM. Replaces the direct ram_write/dmem_data connection.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), width of the RAM data word.
ADDR_WIDTH, 8, width of the RAM address.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cpu_req  input  1  MCU access request; held high until cpu_ack
cpu_we  input  1  1 = write (STORE), 0 = read
cpu_addr  input  ADDR_WIDTH  MCU address
cpu_wdata  input  DATA_WIDTH  MCU write data (ACC)
cpu_ack  output  1  command accepted this cycle
cpu_rvalid  output  1  cpu_rdata valid (read only)
cpu_rdata  output  DATA_WIDTH  read data to regs dmem_data
cpu_stall  output  1  cpu_req & ~cpu_ack; MCU FSM holds state
host_req  input  1  host access request; held until host_ack
host_we  input  1  host write enable
host_addr  input  ADDR_WIDTH  host address
host_wdata  input  DATA_WIDTH  host write data
host_lock  input  1  host exclusive-ownership request
host_ack  output  1  host command accepted
host_rvalid  output  1  host_rdata valid
host_rdata  output  DATA_WIDTH  host read data
host_locked  output  1  lock currently owned by host
ram_en  output  1  RAM command strobe
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en & ~ram_we

Behaviour:
Clock and reset
- One clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all outputs 0; rdata outputs 0; priority pointer = CPU; rsp_pending = 0; lock state = UNLOCKED.
- Reset mid-transaction drops any pending response: no rvalid is produced after reset.

Arbitration and command path
- Decision is combinational from the registered state.
- ram_en, ram_we, ram_addr and ram_wdata are combinational muxes of the granted requester in the same cycle as its ack. Acks are combinational.
- Only one ack per cycle. ack = ram_en for the granted side.
- Round-robin, UNLOCKED state:
  - If only one side requests, grant it.
  - If both request, grant the side named by the pointer.
  - After any grant, the pointer moves to the other side. This prevents starvation: max wait is 1 grant.

Read response
- Read granted in cycle N: rvalid = 1 for the owner in cycle N+1, with rdata = ram_rdata, registered through.
- Back-to-back commands are allowed. A new command in N+1 is independent of the response in N+1.
- Write: no rvalid is produced.

Lock state machine
- States: UNLOCKED, LOCK_WAIT, LOCKED.
- UNLOCKED -> LOCK_WAIT when host_lock = 1.
- LOCK_WAIT: CPU is not granted; waits for any CPU read response in flight to retire, then -> LOCKED.
- LOCKED: host_locked = 1; only the host is granted; cpu_stall = cpu_req.
- LOCKED or LOCK_WAIT -> UNLOCKED when host_lock = 0. Pointer is set to CPU.

Other rules
- Simultaneous requests to the same address are serialized in grant order. No forwarding is needed because the RAM is single-port.
- A requester deasserting req before ack is illegal. The bench flags it with an assertion.
- Widths: no arithmetic; all paths are full DATA_WIDTH/ADDR_WIDTH pass-through.

Decomposition:
- defs.v: add `DMEM_ADDR_WIDTH, lock state encodings `ARB_UNLOCKED/`ARB_LOCK_WAIT/`ARB_LOCKED (2 bits), and grant ids `ARB_CPU/`ARB_HOST.
- No sub-module required. Optionally split the round-robin picker into arb_rr2 (2-input fair picker, pure combinational plus pointer flop).

Test Plan:
1. Reset held 2 cycles, then cpu_req read addr 8'hAE with no host activity -> cpu_ack the same cycle, ram_en=1, ram_we=0, ram_addr=8'hAE; next cycle cpu_rvalid=1, cpu_rdata = RAM content (preloaded 8'h3C); cpu_stall=0 throughout.
2. cpu_req and host_req both high for 4 cycles, continuous back-to-back reads -> acks alternate CPU, HOST, CPU, HOST starting with CPU; no cycle has both acks; each rvalid goes only to the correct owner.
3. Host write 8'h55 to 8'h10, then CPU read of 8'h10 requested in the same cycle, pointer = HOST -> host write first; CPU read acked the next cycle, returning 8'h55; cpu_stall=1 for exactly 1 cycle.
4. host_lock raised while a CPU read is in flight -> LOCK_WAIT for 1 cycle, cpu_rvalid still delivered, then host_locked=1; CPU requests stall for 6 cycles while the host does 3 writes; after host_lock=0, CPU is granted the next cycle.
5. rst asserted in the cycle after a CPU read ack -> cpu_rvalid stays 0; all outputs 0 the next cycle; a subsequent request behaves as in scenario 1.
6. STORE: cpu_we=1, cpu_addr=8'hAE, cpu_wdata=8'h5A -> ram_we=1 with wdata 8'h5A; no cpu_rvalid; a following read of 8'hAE returns 8'h5A.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, lock-state encodings and requester ids for
// the data-RAM arbiter. Encodings keep the legacy numeric values so existing
// waveforms and debug scripts still decode them.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_DATA_WIDTH = 8;
  localparam int unsigned DMEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_UNLOCKED  = 2'd0,
    ARB_LOCK_WAIT = 2'd1,
    ARB_LOCKED    = 2'd2
  } arb_lock_t;

  typedef enum logic {
    ARB_CPU  = 1'b0,
    ARB_HOST = 1'b1
  } arb_id_t;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// dmem_arbiter_rr2: two-input fair picker with its priority pointer.
//   clk, rst     : clock, synchronous active-high reset (pointer -> CPU)
//   req_cpu      : CPU request, already qualified by the lock state
//   req_host     : host request
//   ptr_to_cpu   : force the pointer to CPU (lock release)
//   grant_cpu    : CPU granted this cycle
//   grant_host   : host granted this cycle
module dmem_arbiter_rr2
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_cpu,
  input  logic req_host,
  input  logic ptr_to_cpu,
  output logic grant_cpu,
  output logic grant_host
);

  arb_id_t ptr_q;

  always_comb begin
    grant_cpu  = 1'b0;
    grant_host = 1'b0;
    if (req_cpu && req_host) begin
      grant_cpu  = (ptr_q == ARB_CPU);
      grant_host = (ptr_q == ARB_HOST);
    end else begin
      grant_cpu  = req_cpu;
      grant_host = req_host;
    end
  end

  // After any grant the pointer names the other side, so a waiting
  // requester is passed over at most once.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ARB_CPU;
    end else if (ptr_to_cpu) begin
      ptr_q <= ARB_CPU;
    end else if (grant_cpu) begin
      ptr_q <= ARB_HOST;
    end else if (grant_host) begin
      ptr_q <= ARB_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the MCU control unit
// and the host/debug port. One RAM command per cycle, read data returned the
// cycle after the command, host may take exclusive ownership via host_lock.
//   clk, rst                       : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          : MCU command (req held until cpu_ack)
//   cpu_ack, cpu_stall             : MCU accept / hold indication
//   cpu_rvalid, cpu_rdata          : MCU read response
//   host_req/we/addr/wdata         : host command (req held until host_ack)
//   host_lock, host_locked         : exclusive ownership request / status
//   host_ack, host_rvalid, host_rdata : host accept / read response
//   ram_en/we/addr/wdata, ram_rdata   : RAM port (rdata 1 cycle after read)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_ack,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_locked,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_lock_t lock_q;
  arb_lock_t lock_d;
  logic      rsp_valid_q;
  arb_id_t   rsp_owner_q;
  logic      cpu_elig;
  logic      host_elig;
  logic      grant_cpu;
  logic      grant_host;
  logic      unlock;
  logic      cpu_rd_issue;

  // Gating with rst keeps every output at zero while reset is held.
  assign cpu_elig  = cpu_req & ~rst & (lock_q == ARB_UNLOCKED);
  assign host_elig = host_req & ~rst;
  assign unlock    = (lock_q != ARB_UNLOCKED) & ~host_lock;

  dmem_arbiter_rr2 u_rr2 (
    .clk        (clk),
    .rst        (rst),
    .req_cpu    (cpu_elig),
    .req_host   (host_elig),
    .ptr_to_cpu (unlock),
    .grant_cpu  (grant_cpu),
    .grant_host (grant_host)
  );

  assign cpu_ack      = grant_cpu;
  assign host_ack     = grant_host;
  assign cpu_stall    = cpu_req & ~rst & ~grant_cpu;
  assign cpu_rd_issue = grant_cpu & ~cpu_we;

  always_comb begin
    ram_en    = grant_cpu | grant_host;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_host) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (grant_cpu) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  // Lock sequencing. LOCK_WAIT blocks new CPU grants; a CPU read accepted in
  // the last unlocked cycle returns during LOCK_WAIT, so ownership passes to
  // the host once no CPU read is issued in the current cycle.
  always_comb begin
    lock_d = lock_q;
    unique case (lock_q)
      ARB_UNLOCKED:  if (host_lock) lock_d = ARB_LOCK_WAIT;
      ARB_LOCK_WAIT: begin
        if (!host_lock)        lock_d = ARB_UNLOCKED;
        else if (!cpu_rd_issue) lock_d = ARB_LOCKED;
      end
      ARB_LOCKED:    if (!host_lock) lock_d = ARB_UNLOCKED;
      default:       lock_d = ARB_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= ARB_UNLOCKED;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= ARB_CPU;
    end else begin
      lock_q      <= lock_d;
      rsp_valid_q <= ram_en & ~ram_we;
      rsp_owner_q <= grant_host ? ARB_HOST : ARB_CPU;
    end
  end

  // Response steering: ram_rdata is valid in the cycle after the read, so only
  // the owner select is registered; rst squashes a response still in flight.
  assign cpu_rvalid  = rsp_valid_q & (rsp_owner_q == ARB_CPU) & ~rst;
  assign host_rvalid = rsp_valid_q & (rsp_owner_q == ARB_HOST) & ~rst;
  assign cpu_rdata   = cpu_rvalid ? ram_rdata : '0;
  assign host_rdata  = host_rvalid ? ram_rdata : '0;
  assign host_locked = (lock_q == ARB_LOCKED) & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_ack, cpu_rvalid, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_lock, host_ack, host_rvalid, host_locked;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] ram_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_ack(host_ack), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_locked(host_locked),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Requesters must hold req until acked.
  a_cpu_hold: assert property (@(posedge clk) disable iff (rst)
    (cpu_req && !cpu_ack) |=> cpu_req) else $error("cpu_req dropped before cpu_ack");
  a_host_hold: assert property (@(posedge clk) disable iff (rst)
    (host_req && !host_ack) |=> host_req) else $error("host_req dropped before host_ack");

  typedef struct packed {
    logic       rst, creq, cwe;
    logic [7:0] caddr, cwd;
    logic       hreq, hwe;
    logic [7:0] haddr, hwd;
    logic       hlock;
    logic       e_cack, e_hack, e_en, e_we;
    logic [7:0] e_addr, e_wd;
    logic       e_crv;
    logic [7:0] e_crd;
    logic       e_hrv;
    logic [7:0] e_hrd;
    logic       e_stall, e_lock;
  } vec_t;

  vec_t tbl[$];
  vec_t lck[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    host_req = v.hreq; host_we = v.hwe; host_addr = v.haddr; host_wdata = v.hwd;
    host_lock = v.hlock;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, step past the rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, " cpu_ack"},     32'(cpu_ack),     32'(v.e_cack));
    chk({tag, " host_ack"},    32'(host_ack),    32'(v.e_hack));
    chk({tag, " ram_en"},      32'(ram_en),      32'(v.e_en));
    chk({tag, " cpu_stall"},   32'(cpu_stall),   32'(v.e_stall));
    chk({tag, " host_locked"}, 32'(host_locked), 32'(v.e_lock));
    chk({tag, " cpu_rvalid"},  32'(cpu_rvalid),  32'(v.e_crv));
    chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'(v.e_hrv));
    if (v.e_en) begin
      chk({tag, " ram_we"},    32'(ram_we),    32'(v.e_we));
      chk({tag, " ram_addr"},  32'(ram_addr),  32'(v.e_addr));
      chk({tag, " ram_wdata"}, 32'(ram_wdata), 32'(v.e_wd));
    end
    if (v.e_crv) chk({tag, " cpu_rdata"},  32'(cpu_rdata),  32'(v.e_crd));
    if (v.e_hrv) chk({tag, " host_rdata"}, 32'(host_rdata), 32'(v.e_hrd));
    if (v.rst) begin
      chk({tag, " rst ram_we"},     32'(ram_we),     32'h0);
      chk({tag, " rst ram_addr"},   32'(ram_addr),   32'h0);
      chk({tag, " rst ram_wdata"},  32'(ram_wdata),  32'h0);
      chk({tag, " rst cpu_rdata"},  32'(cpu_rdata),  32'h0);
      chk({tag, " rst host_rdata"}, 32'(host_rdata), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase.
  typedef struct packed { logic owner; logic [7:0] data; } rsp_t;
  rsp_t       m_rsp[$];
  logic [7:0] ref_mem [256];
  int         m_ptr;   // 0 = CPU has priority, 1 = host
  int         m_lock;  // 0 free, 1 waiting for CPU reads, 2 host owns RAM

  initial begin
    // RAM preload: mem[a] = a ^ 8'h92, so mem[8'hAE] = 8'h3C.
    for (int a = 0; a < 256; a++) ram_mem[a] = 8'(a) ^ 8'h92;

    //          rst creq cwe caddr cwd   hreq hwe haddr hwd  hlk | cack hack en we addr wd | crv crd hrv hrd | stall lock
    tbl.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    // single CPU read of AE
    tbl.push_back('{1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h3C,1'b0,8'h00, 1'b0,1'b0});
    // host alone (pointer back to CPU), then four contended cycles
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h30,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0,8'h30,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'h20,8'h00, 1'b1,1'b0,8'h31,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00,1'b1,8'hA2, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b1,1'b0,8'h31,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0,8'h31,8'h00, 1'b1,8'hB2,1'b0,8'h00, 1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b1,1'b0,8'h30,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h21,8'h00, 1'b0,8'h00,1'b1,8'hA3, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'h20,8'h00, 1'b1,1'b0,8'h30,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0,8'h30,8'h00, 1'b1,8'hB3,1'b0,8'h00, 1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00,1'b1,8'hA2, 1'b0,1'b0});
    // pointer = HOST: host write 55 to 10 wins, CPU read of 10 next cycle
    tbl.push_back('{1'b0,1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h10,8'h55,1'b0, 1'b0,1'b1,1'b1,1'b1,8'h10,8'h55, 1'b1,8'hB2,1'b0,8'h00, 1'b1,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h10,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h55,1'b0,8'h00, 1'b0,1'b0});
    // STORE 5A to AE, no response, read back
    tbl.push_back('{1'b0,1'b1,1'b1,8'hAE,8'h5A, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b1,8'hAE,8'h5A, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h5A,1'b0,8'h00, 1'b0,1'b0});
    // reset right after a read ack squashes the response
    tbl.push_back('{1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'hAE,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h5A,1'b0,8'h00, 1'b0,1'b0});

    // Lock sequence: lock raised with a CPU read issued, LOCK_WAIT delivers it,
    // three host writes under lock, CPU stalls 6 cycles, regains RAM after release.
    lck.push_back('{1'b0,1'b1,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b1,1'b0,8'h20,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'hB2,1'b0,8'h00, 1'b1,1'b0});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b1,1'b1,8'h40,8'h11,1'b1, 1'b0,1'b1,1'b1,1'b1,8'h40,8'h11, 1'b0,8'h00,1'b0,8'h00, 1'b1,1'b1});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b1,1'b1,8'h41,8'h22,1'b1, 1'b0,1'b1,1'b1,1'b1,8'h41,8'h22, 1'b0,8'h00,1'b0,8'h00, 1'b1,1'b1});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b1,1'b1,8'h42,8'h33,1'b1, 1'b0,1'b1,1'b1,1'b1,8'h42,8'h33, 1'b0,8'h00,1'b0,8'h00, 1'b1,1'b1});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b1,1'b1});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b1,1'b1});
    lck.push_back('{1'b0,1'b1,1'b0,8'h21,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0,8'h21,8'h00, 1'b0,8'h00,1'b0,8'h00, 1'b0,1'b0});
    lck.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h41,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0,8'h41,8'h00, 1'b1,8'hB3,1'b0,8'h00, 1'b0,1'b0});
    lck.push_back('{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b1,8'h22, 1'b0,1'b0});

    #1;
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));
    foreach (lck[i]) run_vec(lck[i], $sformatf("lock%0d", i));

    // Random phase against a transaction-level model.
    begin
      logic       c_pend, h_pend, hl, c_we, h_we;
      logic [7:0] c_addr, c_wd, h_addr, h_wd;
      int         g;
      logic       e_crv, e_hrv;
      logic [7:0] e_rd;
      vec_t       idle;
      idle = '0;
      idle.rst = 1'b1;
      drive(idle);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ptr = 0; m_lock = 0; m_rsp.delete();
      for (int a = 0; a < 256; a++) ref_mem[a] = ram_mem[a];
      c_pend = 1'b0; h_pend = 1'b0; hl = 1'b0;
      c_we = 1'b0; h_we = 1'b0; c_addr = '0; h_addr = '0; c_wd = '0; h_wd = '0;
      for (int n = 0; n < 3000; n++) begin
        if (!c_pend && $urandom_range(1, 0) == 1) begin
          c_pend = 1'b1; c_we = 1'($urandom_range(1, 0));
          c_addr = 8'h40 + 8'($urandom_range(7, 0)); c_wd = 8'($urandom);
        end
        if (!h_pend && $urandom_range(1, 0) == 1) begin
          h_pend = 1'b1; h_we = 1'($urandom_range(1, 0));
          h_addr = 8'h40 + 8'($urandom_range(7, 0)); h_wd = 8'($urandom);
        end
        if ($urandom_range(15, 0) == 0) hl = ~hl;
        cpu_req = c_pend; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        host_req = h_pend; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
        host_lock = hl;

        // Who owns the RAM this cycle: CPU only when the host holds no lock claim.
        g = -1;
        if (c_pend && m_lock == 0 && h_pend) g = m_ptr;
        else if (c_pend && m_lock == 0)      g = 0;
        else if (h_pend)                     g = 1;
        e_crv = (m_rsp.size() > 0) && (m_rsp[0].owner == 1'b0);
        e_hrv = (m_rsp.size() > 0) && (m_rsp[0].owner == 1'b1);
        e_rd  = (m_rsp.size() > 0) ? m_rsp[0].data : 8'h00;

        @(negedge clk);
        chk($sformatf("rnd%0d cpu_ack", n),     32'(cpu_ack),     32'(g == 0));
        chk($sformatf("rnd%0d host_ack", n),    32'(host_ack),    32'(g == 1));
        chk($sformatf("rnd%0d ram_en", n),      32'(ram_en),      32'(g >= 0));
        chk($sformatf("rnd%0d cpu_stall", n),   32'(cpu_stall),   32'(c_pend && g != 0));
        chk($sformatf("rnd%0d host_locked", n), 32'(host_locked), 32'(m_lock == 2));
        chk($sformatf("rnd%0d cpu_rvalid", n),  32'(cpu_rvalid),  32'(e_crv));
        chk($sformatf("rnd%0d host_rvalid", n), 32'(host_rvalid), 32'(e_hrv));
        if (e_crv) chk($sformatf("rnd%0d cpu_rdata", n),  32'(cpu_rdata),  32'(e_rd));
        if (e_hrv) chk($sformatf("rnd%0d host_rdata", n), 32'(host_rdata), 32'(e_rd));
        if (g == 0) begin
          chk($sformatf("rnd%0d ram_we", n),   32'(ram_we),   32'(c_we));
          chk($sformatf("rnd%0d ram_addr", n), 32'(ram_addr), 32'(c_addr));
          if (c_we) chk($sformatf("rnd%0d ram_wdata", n), 32'(ram_wdata), 32'(c_wd));
        end else if (g == 1) begin
          chk($sformatf("rnd%0d ram_we", n),   32'(ram_we),   32'(h_we));
          chk($sformatf("rnd%0d ram_addr", n), 32'(ram_addr), 32'(h_addr));
          if (h_we) chk($sformatf("rnd%0d ram_wdata", n), 32'(ram_wdata), 32'(h_wd));
        end

        // Advance the model by one clock.
        m_rsp.delete();
        if (g == 0) begin
          if (c_we) ref_mem[c_addr] = c_wd;
          else      m_rsp.push_back('{1'b0, ref_mem[c_addr]});
          c_pend = 1'b0;
          m_ptr = 1;
        end else if (g == 1) begin
          if (h_we) ref_mem[h_addr] = h_wd;
          else      m_rsp.push_back('{1'b1, ref_mem[h_addr]});
          h_pend = 1'b0;
          m_ptr = 0;
        end
        if (m_lock != 0 && !hl) begin
          m_lock = 0;
          m_ptr = 0;
        end else if (m_lock == 0 && hl) begin
          m_lock = 1;
        end else if (m_lock == 1 && !(m_rsp.size() > 0 && m_rsp[0].owner == 1'b0)) begin
          m_lock = 2;
        end
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
